// File: rtl/timebase_gen_pkg.sv
// Shared constants and helpers for the clock/calendar timebase.
// The board clock frequency lives here so every block that divides it agrees on one value.
package timebase_gen_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 100_000_000;

  // Half-period limit in cycles minus one; truncating division.
  function automatic int unsigned half_limit(input int unsigned clk_hz,
                                             input int unsigned out_hz);
    return clk_hz / (2 * out_hz) - 1;
  endfunction

endpackage

// File: rtl/timebase_gen_if.sv
// Control inputs and divided outputs of the timebase, grouped as one bundle.
interface timebase_if;
  logic enable;
  logic sync_clear;
  logic step;
  logic fast_mode;
  logic clk_1Hz;
  logic tick_1Hz;
  logic blink;

  modport master (
    output enable, sync_clear, step, fast_mode,
    input  clk_1Hz, tick_1Hz, blink
  );

  modport slave (
    input  enable, sync_clear, step, fast_mode,
    output clk_1Hz, tick_1Hz, blink
  );
endinterface

// File: rtl/timebase_gen_div.sv
// One half-period counter plus toggle flop; wrap flags the cycle in which q will toggle.
module timebase_div #(
  parameter int unsigned          LIMIT_W   = 32,
  parameter logic [LIMIT_W-1:0]   HALF      = LIMIT_W'(9),
  parameter logic [LIMIT_W-1:0]   FAST_HALF = LIMIT_W'(4),
  parameter logic                 INIT      = 1'b0
) (
  input  logic clk,
  input  logic run,
  input  logic clear,
  input  logic fast,
  output logic q,
  output logic wrap
);

  logic [LIMIT_W-1:0] cnt;
  logic [LIMIT_W-1:0] limit;
  logic               at_limit;

  // >= so a drop to the fast limit while cnt sits above it wraps immediately.
  always_comb begin
    limit    = fast ? FAST_HALF : HALF;
    at_limit = (cnt >= limit);
    wrap     = run & at_limit & ~clear;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
      q   <= INIT;
    end else if (run) begin
      if (at_limit) begin
        cnt <= '0;
        q   <= ~q;
      end else begin
        cnt <= cnt + LIMIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/timebase_gen.sv
// Timebase top: slow clock + tick strobe, independent blink wave, run/hold, re-phase,
// manual single-step and fast mode. Every output comes straight from a flop.
module timebase_gen
  import timebase_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned BLINK_HZ    = 2,
  parameter int unsigned FAST_HALF   = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  timebase_if.slave   ctl
);

  localparam int unsigned TICK_HALF  = half_limit(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned BLINK_HALF = half_limit(CLK_FREQ_HZ, BLINK_HZ);

  logic clear;
  logic run;
  logic tick_wrap;
  logic blink_wrap;
  logic clk_q;
  logic blink_q;
  logic tick_q;

  // Reset and re-phase both return the dividers to their power-up phase.
  assign clear = reset | ctl.sync_clear;
  assign run   = ctl.enable;

  timebase_div #(
    .LIMIT_W   (CNT_W),
    .HALF      (CNT_W'(TICK_HALF)),
    .FAST_HALF (CNT_W'(FAST_HALF)),
    .INIT      (1'b0)
  ) u_tick_div (
    .clk   (clk_100MHz),
    .run   (run),
    .clear (clear),
    .fast  (ctl.fast_mode),
    .q     (clk_q),
    .wrap  (tick_wrap)
  );

  timebase_div #(
    .LIMIT_W   (CNT_W),
    .HALF      (CNT_W'(BLINK_HALF)),
    .FAST_HALF (CNT_W'(FAST_HALF)),
    .INIT      (1'b1)
  ) u_blink_div (
    .clk   (clk_100MHz),
    .run   (run),
    .clear (clear),
    .fast  (ctl.fast_mode),
    .q     (blink_q),
    .wrap  (blink_wrap)
  );

  // Tick register: a wrap while the slow clock is low is the upcoming rising edge,
  // so the strobe lands in the same cycle as clk_1Hz goes high. While held, it
  // echoes step one cycle late.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else if (ctl.sync_clear) begin
      tick_q <= 1'b0;
    end else if (!ctl.enable) begin
      tick_q <= ctl.step;
    end else begin
      tick_q <= tick_wrap & ~clk_q;
    end
  end

  assign ctl.clk_1Hz  = clk_q;
  assign ctl.tick_1Hz = tick_q;
  assign ctl.blink    = blink_q;

  logic unused_blink_wrap;
  assign unused_blink_wrap = blink_wrap;

endmodule

// File: tb/tb_timebase_gen.sv
// Directed scenarios followed by random control traffic, checked each cycle against
// a half-period bookkeeping model of the slow clock, blink wave and tick strobe.
module tb_timebase_gen;

  localparam int TH = 9;   // 20/(2*1)-1
  localparam int BH = 4;   // 20/(2*2)-1
  localparam int FH = 1;

  logic clk_100MHz = 1'b0;
  logic reset;

  timebase_if tif ();

  timebase_gen #(
    .CLK_FREQ_HZ (20),
    .TICK_HZ     (1),
    .BLINK_HZ    (2),
    .FAST_HALF   (1),
    .CNT_W       (32)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .ctl        (tif.slave)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int total = 0;
  int bad   = 0;

  // Model: cycles spent in the current half period for each wave, plus levels.
  int   el_t, el_b;
  logic m_clk, m_blink, m_tick;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    logic old_clk;
    int   lt, lb;
    @(posedge clk_100MHz);
    old_clk = m_clk;
    if (reset || tif.sync_clear) begin
      el_t = 0; el_b = 0;
      m_clk = 1'b0; m_blink = 1'b1; m_tick = 1'b0;
    end else begin
      if (tif.enable) begin
        lt = tif.fast_mode ? FH : TH;
        lb = tif.fast_mode ? FH : BH;
        if (el_t >= lt) begin el_t = 0; m_clk = ~m_clk; end else el_t++;
        if (el_b >= lb) begin el_b = 0; m_blink = ~m_blink; end else el_b++;
      end
      m_tick = (m_clk && !old_clk) || (!tif.enable && tif.step);
    end
    #1;
    chk({tag, "_clk"},   tif.clk_1Hz,  m_clk);
    chk({tag, "_tick"},  tif.tick_1Hz, m_tick);
    chk({tag, "_blink"}, tif.blink,    m_blink);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tif.sync_clear = 1'b0; tif.step = 1'b0; tif.enable = 1'b0; tif.fast_mode = 1'b0;
    cyc("rst");
    cyc("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tif.enable = 1'b0; tif.sync_clear = 1'b0; tif.step = 1'b0; tif.fast_mode = 1'b0;
    el_t = 0; el_b = 0; m_clk = 1'b0; m_blink = 1'b1; m_tick = 1'b0;

    // Reset values
    do_reset();
    chk("reset_clk",   tif.clk_1Hz,  1'b0);
    chk("reset_tick",  tif.tick_1Hz, 1'b0);
    chk("reset_blink", tif.blink,    1'b1);

    // 1: free run for 60 cycles
    tif.enable = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cyc("run");
      if (i == 5)  chk("s1_blink_fall", tif.blink, 1'b0);
      if (i == 9)  chk("s1_pre_rise", tif.clk_1Hz, 1'b0);
      if (i == 10) chk("s1_first_rise", tif.tick_1Hz, 1'b1);
      if (i == 11) chk("s1_tick_width", tif.tick_1Hz, 1'b0);
      if (i == 30) chk("s1_tick30", tif.tick_1Hz, 1'b1);
      if (i == 50) chk("s1_tick50", tif.tick_1Hz, 1'b1);
    end

    // 2: hold at cycle 15 for 20 cycles, then resume with 5 remaining
    do_reset();
    tif.enable = 1'b1;
    repeat (15) cyc("pre_hold");
    tif.enable = 1'b0;
    repeat (20) cyc("hold");
    chk("s2_hold_clk", tif.clk_1Hz, 1'b1);
    tif.enable = 1'b1;
    repeat (4) cyc("resume");
    chk("s2_before_fall", tif.clk_1Hz, 1'b1);
    cyc("resume");
    chk("s2_fall", tif.clk_1Hz, 1'b0);

    // 3: single step, then step held 3 cycles
    tif.enable = 1'b0;
    tif.step = 1'b1; cyc("step1");
    chk("s3_step_tick", tif.tick_1Hz, 1'b1);
    tif.step = 1'b0; cyc("step_gap");
    chk("s3_step_end", tif.tick_1Hz, 1'b0);
    cyc("step_gap");
    tif.step = 1'b1;
    repeat (3) cyc("step3");
    tif.step = 1'b0;
    cyc("step_off");
    chk("s3_step_off", tif.tick_1Hz, 1'b0);
    chk("s3_clk_kept", tif.clk_1Hz, 1'b0);
    tif.enable = 1'b1; tif.step = 1'b1;
    repeat (3) cyc("step_ignored");
    tif.step = 1'b0;

    // 4: switch to fast mode at counter value 7
    do_reset();
    tif.enable = 1'b1;
    repeat (7) cyc("pre_fast");
    tif.fast_mode = 1'b1;
    cyc("fast_wrap");
    chk("s4_fast_wrap", tif.tick_1Hz, 1'b1);
    repeat (16) cyc("fast");
    tif.fast_mode = 1'b0;

    // 5: sync_clear on the wrap cycle
    do_reset();
    tif.enable = 1'b1;
    repeat (9) cyc("pre_clear");
    tif.sync_clear = 1'b1;
    cyc("clear");
    chk("s5_clear_tick",  tif.tick_1Hz, 1'b0);
    chk("s5_clear_clk",   tif.clk_1Hz,  1'b0);
    chk("s5_clear_blink", tif.blink,    1'b1);
    tif.sync_clear = 1'b0;
    repeat (9) cyc("post_clear");
    chk("s5_no_early_rise", tif.clk_1Hz, 1'b0);
    cyc("post_clear");
    chk("s5_rise", tif.tick_1Hz, 1'b1);

    // 6: reset mid-period with step high
    repeat (3) cyc("mid");
    tif.enable = 1'b0; tif.step = 1'b1; reset = 1'b1;
    cyc("rst_step");
    chk("s6_tick",  tif.tick_1Hz, 1'b0);
    chk("s6_clk",   tif.clk_1Hz,  1'b0);
    chk("s6_blink", tif.blink,    1'b1);
    reset = 1'b0; tif.step = 1'b0;

    // Random control traffic
    for (int i = 0; i < 800; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      tif.sync_clear = ($urandom_range(0, 31) == 0);
      tif.enable     = ($urandom_range(0, 3) != 0);
      tif.step       = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) tif.fast_mode = ~tif.fast_mode;
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
